// File: rtl/core_pkg.sv
// Shared bus-sequencer types and access-size encodings, also used by
// execute and the load/store alignment path.
package core_pkg;

  typedef enum logic [2:0] {
    BUS_IDLE,
    BUS_FETCH,
    BUS_DATA_ADDR,
    BUS_DATA_XFER,
    BUS_ERROR
  } bus_state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // Size 2'b11 is handled as a full word everywhere.
  function automatic logic is_sub_word(input logic [1:0] size);
    return (size == SIZE_BYTE) || (size == SIZE_HALF);
  endfunction

endpackage

// File: rtl/byte_lane_decoder.sv
// Maps an access size and low address bits to memory byte lanes and flags
// misaligned halfword/word accesses. Purely combinational.
module byte_lane_decoder
  import core_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] offset,
  output logic [3:0] byte_en,
  output logic       misaligned
);

  always_comb begin
    byte_en    = 4'h0;
    misaligned = 1'b0;
    case (size)
      SIZE_BYTE: byte_en = 4'b0001 << offset;
      SIZE_HALF: begin
        byte_en    = 4'b0011 << offset;
        misaligned = offset[0];
      end
      default: begin
        byte_en    = 4'hF;
        misaligned = (offset != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/bus_sequencer.sv
// Owner of the single shared memory port: sequences instruction fetches,
// PC jumps and execute's loads/stores, with a wait-state timeout.
module bus_sequencer
  import core_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       instr_ready,
  output logic       instr_valid,
  input  logic       jump_req,
  output logic       jump_ack,
  input  logic       data_req,
  input  logic       data_write,
  input  logic [1:0] data_size,
  output logic       data_done,
  output logic       data_error,
  input  logic [1:0] data_offset,
  output logic       pc_write,
  output logic       pc_jump,
  output logic       pc_forward_address,
  output logic       pc_use_offset,
  output logic       mem_valid,
  input  logic       mem_ready,
  output logic       mem_we,
  output logic [3:0] mem_byte_en,
  output logic       bus_error
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  bus_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bus_error_q, bus_error_d;
  logic [CNT_W-1:0] cnt_inc;
  logic [3:0]       lane_en;
  logic             lane_misaligned;

  byte_lane_decoder u_lanes (
    .size       (data_size),
    .offset     (data_offset),
    .byte_en    (lane_en),
    .misaligned (lane_misaligned)
  );

  assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
  assign bus_error = bus_error_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= BUS_IDLE;
      cnt_q       <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bus_error_q <= bus_error_d;
    end
  end

  // Strobes are decoded from state; only the completion pulses look at mem_ready.
  always_comb begin
    state_d            = state_q;
    cnt_d              = cnt_q;
    bus_error_d        = bus_error_q;
    instr_valid        = 1'b0;
    jump_ack           = 1'b0;
    data_done          = 1'b0;
    data_error         = 1'b0;
    pc_write           = 1'b0;
    pc_jump            = 1'b0;
    pc_forward_address = 1'b0;
    pc_use_offset      = 1'b0;
    mem_valid          = 1'b0;
    mem_we             = 1'b0;
    mem_byte_en        = 4'h0;

    case (state_q)
      BUS_IDLE: begin
        if (jump_req) begin
          pc_jump  = 1'b1;
          jump_ack = 1'b1;
        end else if (data_req) begin
          state_d = BUS_DATA_ADDR;
        end else if (instr_ready) begin
          state_d = BUS_FETCH;
          cnt_d   = '0;
        end
      end

      BUS_FETCH: begin
        mem_valid   = 1'b1;
        mem_byte_en = 4'hF;
        if (mem_ready) begin
          instr_valid = 1'b1;
          pc_write    = 1'b1;
          state_d     = BUS_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_MAX) begin
            bus_error_d = 1'b1;
            state_d     = BUS_ERROR;
          end
        end
      end

      BUS_DATA_ADDR: begin
        pc_forward_address = 1'b1;
        pc_use_offset      = is_sub_word(data_size);
        state_d            = BUS_DATA_XFER;
        cnt_d              = '0;
      end

      // data_offset is only trustworthy here, after the PC latched it.
      BUS_DATA_XFER: begin
        pc_forward_address = 1'b1;
        pc_use_offset      = is_sub_word(data_size);
        if (lane_misaligned) begin
          data_done  = 1'b1;
          data_error = 1'b1;
          state_d    = BUS_IDLE;
        end else begin
          mem_valid   = 1'b1;
          mem_we      = data_write;
          mem_byte_en = lane_en;
          if (mem_ready) begin
            data_done = 1'b1;
            state_d   = BUS_IDLE;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              bus_error_d = 1'b1;
              state_d     = BUS_ERROR;
            end
          end
        end
      end

      BUS_ERROR: state_d = BUS_ERROR;

      default: state_d = BUS_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: directed requests push expected
// completions; a negedge monitor pops and compares each observed completion.
module tb_bus_sequencer;

  typedef struct packed {
    logic       pc_jump;
    logic       pc_write;
    logic       done;
    logic       err;
    logic       we;
    logic [3:0] be;
    logic       use_off;
    logic [4:0] vcyc;
    logic [1:0] acyc;
  } rec_t;

  localparam int EV_ACK  = 0;
  localparam int EV_IV   = 1;
  localparam int EV_DONE = 2;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       instr_ready = 1'b0;
  logic       jump_req = 1'b0;
  logic       data_req = 1'b0;
  logic       data_write = 1'b0;
  logic [1:0] data_size = 2'b00;
  logic [1:0] data_offset = 2'b00;
  logic       mem_ready = 1'b0;
  logic       instr_valid, jump_ack, data_done, data_error;
  logic       pc_write, pc_jump, pc_forward_address, pc_use_offset;
  logic       mem_valid, mem_we, bus_error;
  logic [3:0] mem_byte_en;

  int   errors = 0;
  int   checks = 0;
  int   mem_wait = 0;
  rec_t sb_q[$];

  bus_sequencer #(.TIMEOUT(16)) dut (
    .clock              (clock),
    .reset              (reset),
    .instr_ready        (instr_ready),
    .instr_valid        (instr_valid),
    .jump_req           (jump_req),
    .jump_ack           (jump_ack),
    .data_req           (data_req),
    .data_write         (data_write),
    .data_size          (data_size),
    .data_done          (data_done),
    .data_error         (data_error),
    .data_offset        (data_offset),
    .pc_write           (pc_write),
    .pc_jump            (pc_jump),
    .pc_forward_address (pc_forward_address),
    .pc_use_offset      (pc_use_offset),
    .mem_valid          (mem_valid),
    .mem_ready          (mem_ready),
    .mem_we             (mem_we),
    .mem_byte_en        (mem_byte_en),
    .bus_error          (bus_error)
  );

  always #5 clock = ~clock;

  function automatic logic [13:0] all_outs();
    return {instr_valid, jump_ack, data_done, data_error, pc_write, pc_jump,
            pc_forward_address, pc_use_offset, mem_valid, mem_we, mem_byte_en, bus_error};
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: answers after mem_wait wait states, decided just after each rising edge.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(posedge clock);
      #2;
      if (mem_valid) begin
        if (wcnt >= mem_wait) mem_ready = 1'b1;
        else begin
          mem_ready = 1'b0;
          wcnt++;
        end
      end else begin
        mem_ready = 1'b0;
        wcnt = 0;
      end
    end
  end

  // Monitor: collects per-transaction observations and scores them at completion.
  int mon_vcnt = 0;
  int mon_acnt = 0;
  always @(negedge clock) begin
    rec_t act, exp;
    if (reset) begin
      mon_vcnt = 0;
      mon_acnt = 0;
    end else begin
      if (mem_valid) mon_vcnt++;
      if (pc_forward_address && !mem_valid && !data_done) mon_acnt++;
      checks++;
      if ((pc_write != instr_valid) || (pc_jump != jump_ack) || (data_error && !data_done)) begin
        errors++;
        $display("[TB] FAIL strobe_pairing: pc_write=%b instr_valid=%b pc_jump=%b jump_ack=%b data_error=%b data_done=%b",
                 pc_write, instr_valid, pc_jump, jump_ack, data_error, data_done);
      end
      if (jump_ack || instr_valid || data_done) begin
        act = '0;
        act.pc_jump  = pc_jump;
        act.pc_write = pc_write;
        act.done     = data_done;
        act.err      = data_error;
        act.we       = mem_valid ? mem_we : 1'b0;
        act.be       = mem_valid ? mem_byte_en : 4'h0;
        act.use_off  = pc_use_offset;
        act.vcyc     = (mon_vcnt > 31) ? 5'd31 : 5'(mon_vcnt);
        act.acyc     = (mon_acnt > 3) ? 2'd3 : 2'(mon_acnt);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_completion: got 0x%0h expected none", act);
        end else begin
          exp = sb_q.pop_front();
          check_output("completion", 32'(act), 32'(exp));
        end
        mon_vcnt = 0;
        mon_acnt = 0;
      end
    end
  end

  task automatic wait_evt(input int which, input string name);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 60 && !hit; i++) begin
      @(negedge clock);
      #1;
      case (which)
        EV_ACK:  hit = jump_ack;
        EV_IV:   hit = instr_valid;
        default: hit = data_done;
      endcase
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout_%s: got no pulse expected pulse within 60 cycles", name);
    end
  endtask

  function automatic rec_t exp_jump();
    rec_t r = '0;
    r.pc_jump = 1'b1;
    return r;
  endfunction

  function automatic rec_t exp_fetch(input int waits);
    rec_t r = '0;
    r.pc_write = 1'b1;
    r.be       = 4'hF;
    r.vcyc     = 5'(waits + 1);
    return r;
  endfunction

  function automatic rec_t exp_data(input logic wr, input int waits, input logic [3:0] be,
                                    input logic err, input logic use_off);
    rec_t r = '0;
    r.done    = 1'b1;
    r.err     = err;
    r.we      = err ? 1'b0 : wr;
    r.be      = err ? 4'h0 : be;
    r.use_off = use_off;
    r.vcyc    = err ? 5'd0 : 5'(waits + 1);
    r.acyc    = 2'd1;
    return r;
  endfunction

  task automatic apply_stimulus_fetch(input int waits);
    sb_q.push_back(exp_fetch(waits));
    @(posedge clock);
    #1;
    mem_wait = waits;
    instr_ready = 1'b1;
    wait_evt(EV_IV, "fetch");
    instr_ready = 1'b0;
  endtask

  task automatic apply_stimulus_data(input logic wr, input logic [1:0] sz, input logic [1:0] off,
                                     input int waits, input logic [3:0] be, input logic err,
                                     input logic use_off);
    sb_q.push_back(exp_data(wr, waits, be, err, use_off));
    @(posedge clock);
    #1;
    mem_wait    = waits;
    data_write  = wr;
    data_size   = sz;
    data_offset = off;
    data_req    = 1'b1;
    wait_evt(EV_DONE, "data");
    data_req = 1'b0;
  endtask

  initial begin
    int vseen;

    // Reset state, then fetch with zero wait states straight out of reset.
    instr_ready = 1'b1;
    repeat (2) @(negedge clock);
    check_output("reset_outputs", 32'(all_outs()), 32'h0);
    sb_q.push_back(exp_fetch(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check_output("fetch_cycle1_no_valid", 32'(instr_valid), 32'h0);
    @(negedge clock);
    check_output("fetch_cycle2_valid", 32'(instr_valid), 32'h1);
    #1;
    instr_ready = 1'b0;

    apply_stimulus_fetch(3);
    check_output("no_bus_error_after_waits", 32'(bus_error), 32'h0);

    apply_stimulus_data(1'b1, 2'b01, 2'd2, 1, 4'b1100, 1'b0, 1'b1);
    apply_stimulus_data(1'b0, 2'b10, 2'd1, 0, 4'h0, 1'b1, 1'b0);

    // Simultaneous requests: jump, then data, then fetch.
    sb_q.push_back(exp_jump());
    sb_q.push_back(exp_data(1'b0, 0, 4'b1000, 1'b0, 1'b1));
    sb_q.push_back(exp_fetch(0));
    @(posedge clock);
    #1;
    mem_wait    = 0;
    data_write  = 1'b0;
    data_size   = 2'b00;
    data_offset = 2'd3;
    jump_req    = 1'b1;
    data_req    = 1'b1;
    instr_ready = 1'b1;
    wait_evt(EV_ACK, "jump");
    jump_req = 1'b0;
    wait_evt(EV_DONE, "combo_data");
    data_req = 1'b0;
    wait_evt(EV_IV, "combo_fetch");
    instr_ready = 1'b0;

    apply_stimulus_data(1'b1, 2'b11, 2'd0, 2, 4'hF, 1'b0, 1'b0);
    apply_stimulus_data(1'b0, 2'b01, 2'd3, 0, 4'h0, 1'b1, 1'b1);
    apply_stimulus_data(1'b0, 2'b00, 2'd1, 0, 4'b0010, 1'b0, 1'b1);

    // Memory never answers: timeout after 16 waiting cycles, then async reset.
    @(posedge clock);
    #1;
    mem_wait = 100000;
    instr_ready = 1'b1;
    vseen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (mem_valid) vseen++;
      if (bus_error) break;
    end
    check_output("timeout_wait_cycles", 32'(vseen), 32'd16);
    check_output("timeout_bus_error", 32'(bus_error), 32'h1);
    check_output("error_state_outputs", 32'(all_outs()), 32'h1);
    repeat (3) @(negedge clock);
    check_output("error_is_sticky", 32'(all_outs()), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    check_output("async_reset_clears", 32'(all_outs()), 32'h0);
    instr_ready = 1'b0;
    mem_wait = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    check_output("idle_after_reset", 32'(all_outs()), 32'h0);

    check_output("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
